// File: rtl/gpio_ahb_arbiter.sv
// Two-master AHB-Lite arbiter for the shared GPIO slave bus. Each master owns a one-deep
// buffer that holds an address phase which lost arbitration or arrived during a slave stall.
module gpio_ahb_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] M0_HADDR,
  input  logic [1:0]  M0_HTRANS,
  input  logic        M0_HWRITE,
  input  logic [2:0]  M0_HSIZE,
  input  logic [31:0] M0_HWDATA,
  output logic [31:0] M0_HRDATA,
  output logic        M0_HREADY,
  output logic        M0_HRESP,
  input  logic [31:0] M1_HADDR,
  input  logic [1:0]  M1_HTRANS,
  input  logic        M1_HWRITE,
  input  logic [2:0]  M1_HSIZE,
  input  logic [31:0] M1_HWDATA,
  output logic [31:0] M1_HRDATA,
  output logic        M1_HREADY,
  output logic        M1_HRESP,
  output logic [31:0] S_HADDR,
  output logic [1:0]  S_HTRANS,
  output logic        S_HWRITE,
  output logic [2:0]  S_HSIZE,
  output logic [31:0] S_HWDATA,
  output logic        S_HREADY,
  output logic        S_HMASTER,
  input  logic [31:0] S_HRDATA,
  input  logic        S_HREADYOUT,
  input  logic        S_HRESP
);
  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
  } aphase_t;

  aphase_t [1:0] live;
  aphase_t [1:0] src;
  aphase_t [1:0] hold_q;
  aphase_t [1:0] hold_d;
  aphase_t       gnt;
  logic [1:0]    pend_q, pend_d;
  logic          dval_q, dval_d;
  logic          down_q, down_d;
  logic          last_q, last_d;
  logic [1:0]    hready, live_req, req, gsel, accept, capture;
  logic          gnt_any, winner;

  assign live[0] = {M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE};
  assign live[1] = {M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE};

  // A buffered master is kept in a stretched data phase until its transfer is granted.
  assign hready[0] = (dval_q && !down_q) ? S_HREADYOUT : !pend_q[0];
  assign hready[1] = (dval_q &&  down_q) ? S_HREADYOUT : !pend_q[1];

  assign live_req = {live[1].trans[1], live[0].trans[1]} & hready;
  assign req      = pend_q | live_req;
  assign src[0]   = pend_q[0] ? hold_q[0] : live[0];
  assign src[1]   = pend_q[1] ? hold_q[1] : live[1];

  always_comb begin
    gnt_any = |req;
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = FIXED_PRIO ? 1'b0 : ~last_q;
      default: winner = last_q;
    endcase
  end

  assign gnt     = winner ? src[1] : src[0];
  assign gsel    = gnt_any ? {winner, ~winner} : 2'b00;
  assign accept  = {2{S_HREADYOUT}} & gsel;
  // Any live request that is not taken by the slave this cycle must be buffered.
  assign capture = live_req & ~pend_q & ~accept;

  assign pend_d    = (pend_q | capture) & ~accept;
  assign dval_d    = S_HREADYOUT ? gnt_any : dval_q;
  assign down_d    = (S_HREADYOUT && gnt_any) ? winner : down_q;
  assign last_d    = (S_HREADYOUT && (&req)) ? winner : last_q;
  assign hold_d[0] = capture[0] ? live[0] : hold_q[0];
  assign hold_d[1] = capture[1] ? live[1] : hold_q[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q <= 2'b00;
      dval_q <= 1'b0;
      down_q <= 1'b0;
      last_q <= 1'b1;
    end else begin
      pend_q <= pend_d;
      dval_q <= dval_d;
      down_q <= down_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge HCLK) begin
    hold_q <= hold_d;
  end

  assign S_HADDR   = gnt.addr;
  assign S_HTRANS  = gnt_any ? gnt.trans : 2'b00;
  assign S_HWRITE  = gnt.write;
  assign S_HSIZE   = gnt.size;
  assign S_HMASTER = winner;
  assign S_HWDATA  = down_q ? M1_HWDATA : M0_HWDATA;
  assign S_HREADY  = S_HREADYOUT;

  assign M0_HRDATA = S_HRDATA;
  assign M1_HRDATA = S_HRDATA;
  assign M0_HREADY = hready[0];
  assign M1_HREADY = hready[1];
  assign M0_HRESP  = dval_q & ~down_q & S_HRESP;
  assign M1_HRESP  = dval_q &  down_q & S_HRESP;

endmodule

// File: tb/tb_gpio_ahb_arbiter.sv
// Bench for gpio_ahb_arbiter: a round-robin and a fixed-priority instance share the stimulus
// and are each compared every cycle against a transaction-level model of the arbitration rules.
module tb_gpio_ahb_arbiter;
  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic [31:0] M0_HADDR, M1_HADDR, M0_HWDATA, M1_HWDATA, S_HRDATA;
  logic [1:0]  M0_HTRANS, M1_HTRANS;
  logic        M0_HWRITE, M1_HWRITE, S_HREADYOUT, S_HRESP;
  logic [2:0]  M0_HSIZE, M1_HSIZE;

  logic [31:0] m0_hrdata [2];
  logic [31:0] m1_hrdata [2];
  logic [31:0] s_haddr   [2];
  logic [31:0] s_hwdata  [2];
  logic        m0_hready [2];
  logic        m1_hready [2];
  logic        m0_hresp  [2];
  logic        m1_hresp  [2];
  logic        s_hwrite  [2];
  logic        s_hready  [2];
  logic        s_hmaster [2];
  logic [1:0]  s_htrans  [2];
  logic [2:0]  s_hsize   [2];

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    gpio_ahb_arbiter #(.FIXED_PRIO(g == 1)) u_dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .M0_HADDR(M0_HADDR), .M0_HTRANS(M0_HTRANS), .M0_HWRITE(M0_HWRITE), .M0_HSIZE(M0_HSIZE),
      .M0_HWDATA(M0_HWDATA), .M0_HRDATA(m0_hrdata[g]), .M0_HREADY(m0_hready[g]), .M0_HRESP(m0_hresp[g]),
      .M1_HADDR(M1_HADDR), .M1_HTRANS(M1_HTRANS), .M1_HWRITE(M1_HWRITE), .M1_HSIZE(M1_HSIZE),
      .M1_HWDATA(M1_HWDATA), .M1_HRDATA(m1_hrdata[g]), .M1_HREADY(m1_hready[g]), .M1_HRESP(m1_hresp[g]),
      .S_HADDR(s_haddr[g]), .S_HTRANS(s_htrans[g]), .S_HWRITE(s_hwrite[g]), .S_HSIZE(s_hsize[g]),
      .S_HWDATA(s_hwdata[g]), .S_HREADY(s_hready[g]), .S_HMASTER(s_hmaster[g]),
      .S_HRDATA(S_HRDATA), .S_HREADYOUT(S_HREADYOUT), .S_HRESP(S_HRESP)
    );
  end

  // Model: per instance, a one-entry parking slot per master, the current data-phase owner
  // (-1 when none) and the last contended winner.
  typedef struct {
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        write;
    logic [2:0]  size;
  } aph_t;

  aph_t slot   [2][2];
  bit   parked [2][2];
  int   owner  [2];
  int   lastw  [2];
  aph_t n_slot   [2][2];
  bit   n_parked [2][2];
  int   n_owner  [2];
  int   n_lastw  [2];
  bit   known = 1'b0;
  bit   n_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    aph_t lv [2];
    aph_t g;
    bit   rdy  [2];
    bit   want [2];
    int   n, win;
    logic [31:0] rsp;
    @(negedge HCLK);
    lv[0] = '{M0_HADDR, M0_HTRANS, M0_HWRITE, M0_HSIZE};
    lv[1] = '{M1_HADDR, M1_HTRANS, M1_HWRITE, M1_HSIZE};
    n_known = known || (HRESET === 1'b1);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      for (int m = 0; m < 2; m++) begin
        rdy[m]  = (owner[k] == m) ? (S_HREADYOUT === 1'b1) : !parked[k][m];
        want[m] = parked[k][m] || (lv[m].trans[1] && rdy[m]);
        if (want[m]) n++;
      end
      if (n == 0)      win = -1;
      else if (n == 1) win = want[0] ? 0 : 1;
      else             win = (k == 1) ? 0 : 1 - lastw[k];
      if (known) begin
        chk($sformatf("i%0d_m0_hready", k), 32'(m0_hready[k]), 32'(rdy[0]));
        chk($sformatf("i%0d_m1_hready", k), 32'(m1_hready[k]), 32'(rdy[1]));
        chk($sformatf("i%0d_hmaster", k), 32'(s_hmaster[k]), 32'((win < 0) ? lastw[k] : win));
        if (win < 0) begin
          chk($sformatf("i%0d_htrans_idle", k), 32'(s_htrans[k]), 32'd0);
        end else begin
          g = parked[k][win] ? slot[k][win] : lv[win];
          chk($sformatf("i%0d_htrans", k), 32'(s_htrans[k]), 32'(g.trans));
          chk($sformatf("i%0d_haddr", k), s_haddr[k], g.addr);
          chk($sformatf("i%0d_hwrite", k), 32'(s_hwrite[k]), 32'(g.write));
          chk($sformatf("i%0d_hsize", k), 32'(s_hsize[k]), 32'(g.size));
        end
        if (owner[k] >= 0)
          chk($sformatf("i%0d_hwdata", k), s_hwdata[k], (owner[k] == 1) ? M1_HWDATA : M0_HWDATA);
        rsp = 32'(S_HRESP);
        chk($sformatf("i%0d_m0_hresp", k), 32'(m0_hresp[k]), (owner[k] == 0) ? rsp : 32'd0);
        chk($sformatf("i%0d_m1_hresp", k), 32'(m1_hresp[k]), (owner[k] == 1) ? rsp : 32'd0);
        chk($sformatf("i%0d_m0_hrdata", k), m0_hrdata[k], S_HRDATA);
        chk($sformatf("i%0d_m1_hrdata", k), m1_hrdata[k], S_HRDATA);
        chk($sformatf("i%0d_s_hready", k), 32'(s_hready[k]), 32'(S_HREADYOUT));
      end
      n_owner[k] = owner[k];
      n_lastw[k] = lastw[k];
      for (int m = 0; m < 2; m++) begin
        n_parked[k][m] = parked[k][m];
        n_slot[k][m]   = slot[k][m];
      end
      if (HRESET === 1'b1) begin
        n_owner[k] = -1;
        n_lastw[k] = 1;
        n_parked[k][0] = 1'b0;
        n_parked[k][1] = 1'b0;
      end else begin
        if (S_HREADYOUT === 1'b1) begin
          if (n == 2) n_lastw[k] = win;
          n_owner[k] = win;
          if (win >= 0) n_parked[k][win] = 1'b0;
        end
        for (int m = 0; m < 2; m++) begin
          if (!parked[k][m] && lv[m].trans[1] && rdy[m] && !((S_HREADYOUT === 1'b1) && win == m)) begin
            n_parked[k][m] = 1'b1;
            n_slot[k][m]   = lv[m];
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    known = n_known;
    for (int k = 0; k < 2; k++) begin
      owner[k] = n_owner[k];
      lastw[k] = n_lastw[k];
      for (int m = 0; m < 2; m++) begin
        parked[k][m] = n_parked[k][m];
        slot[k][m]   = n_slot[k][m];
      end
    end
    #1;
  endtask

  task automatic idle();
    M0_HTRANS = 2'b00; M0_HADDR = 32'h0; M0_HWRITE = 1'b0; M0_HSIZE = 3'd2; M0_HWDATA = 32'h0;
    M1_HTRANS = 2'b00; M1_HADDR = 32'h0; M1_HWRITE = 1'b0; M1_HSIZE = 3'd2; M1_HWDATA = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    S_HREADYOUT = 1'b1;
    HRESET = 1'b1;
    sample(); tick();
    HRESET = 1'b0;
  endtask

  initial begin
    int t;
    idle();
    S_HREADYOUT = 1'b1; S_HRESP = 1'b0; S_HRDATA = 32'h0;
    HRESET = 1'b1;
    sample(); tick();
    sample(); tick();
    HRESET = 1'b0;

    // Reset state.
    sample();
    for (int k = 0; k < 2; k++) begin
      chk("rst_htrans", 32'(s_htrans[k]), 32'd0);
      chk("rst_hmaster", 32'(s_hmaster[k]), 32'd1);
      chk("rst_m0_hready", 32'(m0_hready[k]), 32'd1);
      chk("rst_m1_hready", 32'(m1_hready[k]), 32'd1);
      chk("rst_m0_hresp", 32'(m0_hresp[k]), 32'd0);
      chk("rst_m1_hresp", 32'(m1_hresp[k]), 32'd0);
    end
    tick();

    // Uncontended M0 write: address same cycle, write data next cycle.
    M0_HTRANS = 2'b10; M0_HADDR = 32'h4000_0000; M0_HWRITE = 1'b1;
    sample();
    chk("t1_haddr", s_haddr[0], 32'h4000_0000);
    chk("t1_htrans", 32'(s_htrans[0]), 32'd2);
    chk("t1_m0_hready_a", 32'(m0_hready[0]), 32'd1);
    tick();
    idle(); M0_HWDATA = 32'h0000_00A5;
    sample();
    chk("t1_hwdata", s_hwdata[0], 32'h0000_00A5);
    chk("t1_m0_hready_d", 32'(m0_hready[0]), 32'd1);
    tick();

    // Both request in the first cycle after reset: M0 first, M1 buffered.
    do_reset();
    M0_HTRANS = 2'b10; M0_HADDR = 32'h4000_0000;
    M1_HTRANS = 2'b10; M1_HADDR = 32'h4000_0100;
    sample();
    chk("t2_hmaster_a", 32'(s_hmaster[0]), 32'd0);
    chk("t2_haddr_a", s_haddr[0], 32'h4000_0000);
    tick();
    idle();
    sample();
    chk("t2_m1_hready_b", 32'(m1_hready[0]), 32'd0);
    chk("t2_haddr_b", s_haddr[0], 32'h4000_0100);
    chk("t2_hmaster_b", 32'(s_hmaster[0]), 32'd1);
    tick();
    sample();
    chk("t2_m1_hready_c", 32'(m1_hready[0]), 32'd1);
    tick();

    // Continuous contention: round-robin alternates, fixed priority starves M1.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      M0_HTRANS = 2'b10; M0_HADDR = 32'h4000_0000 + 32'(4 * i);
      M1_HTRANS = 2'b10; M1_HADDR = 32'h4000_0100 + 32'(4 * i);
      sample();
      chk("t3_hmaster_rr", 32'(s_hmaster[0]), 32'(i % 2));
      chk("t5_hmaster_fp", 32'(s_hmaster[1]), 32'd0);
      tick();
    end
    M0_HTRANS = 2'b00;
    sample();
    chk("t5_fp_m1_granted", 32'(s_hmaster[1]), 32'd1);
    chk("t5_fp_m1_haddr", s_haddr[1], 32'h4000_0100);
    tick();
    idle(); sample(); tick();

    // M1 read with two wait states; M0 arrives during the wait and goes on the ready cycle.
    do_reset();
    M1_HTRANS = 2'b10; M1_HADDR = 32'h4000_0200;
    sample();
    chk("t4_hmaster_m1", 32'(s_hmaster[0]), 32'd1);
    tick();
    idle(); S_HREADYOUT = 1'b0;
    M0_HTRANS = 2'b10; M0_HADDR = 32'h4000_0010; M0_HWRITE = 1'b1;
    sample();
    chk("t4_m1_wait1", 32'(m1_hready[0]), 32'd0);
    chk("t4_m0_live", 32'(m0_hready[0]), 32'd1);
    tick();
    idle();
    sample();
    chk("t4_m1_wait2", 32'(m1_hready[0]), 32'd0);
    chk("t4_m0_parked", 32'(m0_hready[0]), 32'd0);
    tick();
    S_HREADYOUT = 1'b1; S_HRDATA = 32'h0000_1234;
    sample();
    chk("t4_m1_ready", 32'(m1_hready[0]), 32'd1);
    chk("t4_m1_hrdata", m1_hrdata[0], 32'h0000_1234);
    chk("t4_m0_granted", 32'(s_hmaster[0]), 32'd0);
    chk("t4_m0_haddr", s_haddr[0], 32'h4000_0010);
    chk("t4_m0_htrans", 32'(s_htrans[0]), 32'd2);
    tick();
    idle(); sample(); tick();

    // Reset while M1 is buffered and the slave is stalled.
    do_reset();
    M0_HTRANS = 2'b10; M0_HADDR = 32'h4000_0000;
    M1_HTRANS = 2'b10; M1_HADDR = 32'h4000_0100;
    sample(); tick();
    idle(); S_HREADYOUT = 1'b0;
    sample();
    chk("t6_m1_parked", 32'(m1_hready[0]), 32'd0);
    tick();
    HRESET = 1'b1;
    sample(); tick();
    HRESET = 1'b0;
    sample();
    for (int k = 0; k < 2; k++) begin
      chk("t6_m0_hready", 32'(m0_hready[k]), 32'd1);
      chk("t6_m1_hready", 32'(m1_hready[k]), 32'd1);
      chk("t6_htrans", 32'(s_htrans[k]), 32'd0);
    end
    tick();
    S_HREADYOUT = 1'b1;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      t = $urandom_range(0, 2);
      M0_HTRANS = (t == 0) ? 2'b00 : ((t == 1) ? 2'b10 : 2'b11);
      t = $urandom_range(0, 2);
      M1_HTRANS = (t == 0) ? 2'b00 : ((t == 1) ? 2'b10 : 2'b11);
      M0_HADDR  = $urandom; M1_HADDR  = $urandom;
      M0_HWRITE = 1'($urandom_range(0, 1)); M1_HWRITE = 1'($urandom_range(0, 1));
      M0_HSIZE  = 3'($urandom_range(0, 2)); M1_HSIZE  = 3'($urandom_range(0, 2));
      M0_HWDATA = $urandom; M1_HWDATA = $urandom;
      S_HRDATA  = $urandom;
      S_HREADYOUT = ($urandom_range(0, 3) != 0);
      S_HRESP     = ($urandom_range(0, 9) == 0);
      HRESET      = ($urandom_range(0, 49) == 0);
      sample(); tick();
    end
    HRESET = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
